// File: rtl/regfile_sb.sv
// regfile_sb: multi-ported register file with a per-register busy scoreboard.
//
// After reset the block runs an initialisation sweep (INIT) that writes
// every register once, one per clock, then enters RUN and raises ready.
//
// Ports
//   clk                 clock, all state updates on the rising edge
//   rst_n               asynchronous reset, active-low
//   ready               1 once the init sweep has finished (RUN state)
//   wr_en/wr_sel/wr_data  write port (RUN only)
//   rd1_sel/rd1_data    read port 1, combinational data
//   rd2_sel/rd2_data    read port 2, combinational data
//   sb_set/sb_sel       mark a register busy (pending producer)
//   rd1_busy/rd2_busy   busy status of the register selected on each read port
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int ZERO_R0  = 1,
  parameter int INIT_IDX = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     ready,
  input  logic                     wr_en,
  input  logic [$clog2(NREG)-1:0]  wr_sel,
  input  logic [XLEN-1:0]          wr_data,
  input  logic [$clog2(NREG)-1:0]  rd1_sel,
  input  logic [$clog2(NREG)-1:0]  rd2_sel,
  output logic [XLEN-1:0]          rd1_data,
  output logic [XLEN-1:0]          rd2_data,
  input  logic                     sb_set,
  input  logic [$clog2(NREG)-1:0]  sb_sel,
  output logic                     rd1_busy,
  output logic                     rd2_busy
);

  localparam int            AW   = $clog2(NREG);
  localparam logic [AW-1:0] LAST = AW'(NREG - 1);
  localparam bit            Z0   = (ZERO_R0 != 0);
  localparam bit            BYP  = (BYPASS != 0);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [AW-1:0]     idx;
  logic [XLEN-1:0]   rf [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic              run;
  logic              wr_eff;
  logic              sb_eff;
  logic              fwd1, fwd2;
  logic              set1, set2;
  logic              live1, live2;

  // Value loaded into register i by the init sweep.
  function automatic logic [XLEN-1:0] init_val(input logic [AW-1:0] i);
    if (INIT_IDX == 0 || (Z0 && i == '0)) return '0;
    return XLEN'(i);
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nxt;
  end

  // FSM next state: leave INIT on the edge that writes the last register
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (idx == LAST) state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_INIT;
    endcase
  end

  // FSM outputs
  always_comb begin
    run   = (state == S_RUN);
    ready = run;
  end

  // Sweep counter; it only advances in INIT and wraps to 0 as RUN begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              idx <= '0;
    else if (state == S_INIT) idx <= idx + AW'(1);
  end

  // Writes to r0 are dropped when it is hardwired, so its storage is never
  // observed; sb_set to r0 is likewise ignored so r0 can never report busy.
  assign wr_eff = run && wr_en && !(Z0 && wr_sel == '0);
  assign sb_eff = run && sb_set && !(Z0 && sb_sel == '0);

  // Register storage has no reset: contents are defined by the sweep alone.
  always_ff @(posedge clk) begin
    if (state == S_INIT) rf[idx] <= init_val(idx);
    else if (wr_eff)     rf[wr_sel] <= wr_data;
  end

  // Clear-on-write is applied first so a same-index sb_set wins.
  always_comb begin
    busy_nxt = busy;
    if (run && wr_en) busy_nxt[wr_sel] = 1'b0;
    if (sb_eff)       busy_nxt[sb_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  // Read ports. A forwarded write hides the busy bit it is about to clear,
  // unless a same-index sb_set keeps the register busy across the edge.
  assign fwd1  = BYP && wr_en && (wr_sel == rd1_sel);
  assign fwd2  = BYP && wr_en && (wr_sel == rd2_sel);
  assign set1  = sb_set && (sb_sel == rd1_sel);
  assign set2  = sb_set && (sb_sel == rd2_sel);
  assign live1 = run && !(Z0 && rd1_sel == '0);
  assign live2 = run && !(Z0 && rd2_sel == '0);

  assign rd1_data = !live1 ? '0 : (fwd1 ? wr_data : rf[rd1_sel]);
  assign rd2_data = !live2 ? '0 : (fwd2 ? wr_data : rf[rd2_sel]);
  assign rd1_busy = live1 && busy[rd1_sel] && (!fwd1 || set1);
  assign rd2_busy = live2 && busy[rd2_sel] && (!fwd2 || set2);

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: two instances (default parameters, and a small
// 8 x 4-bit, zero-initialised, non-bypassing variant) exercised one after the
// other. Stimulus pushes expected responses into a queue; a monitor on the
// falling edge pops and compares them against the selected instance.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  int          cur;
  logic        rst_a, rst_b;
  logic        wr_en, sb_set;
  logic [4:0]  wr_sel, rd1_sel, rd2_sel, sb_sel;
  logic [31:0] wr_data;
  bit          done = 1'b0;

  logic        ready_a, rd1_busy_a, rd2_busy_a;
  logic [31:0] rd1_data_a, rd2_data_a;
  logic        ready_b, rd1_busy_b, rd2_busy_b;
  logic [3:0]  rd1_data_b, rd2_data_b;

  assign rst_a = (cur == 0) ? rst : 1'b1;
  assign rst_b = (cur == 1) ? rst : 1'b0;

  always #5 clk = ~clk;

  regfile_sb dut_a (
    .clk(clk), .rst_n(rst_a), .ready(ready_a),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd1_sel(rd1_sel), .rd2_sel(rd2_sel),
    .rd1_data(rd1_data_a), .rd2_data(rd2_data_a),
    .sb_set(sb_set), .sb_sel(sb_sel),
    .rd1_busy(rd1_busy_a), .rd2_busy(rd2_busy_a)
  );

  regfile_sb #(.XLEN(4), .NREG(8), .ZERO_R0(1), .INIT_IDX(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_b), .ready(ready_b),
    .wr_en(wr_en), .wr_sel(wr_sel[2:0]), .wr_data(wr_data[3:0]),
    .rd1_sel(rd1_sel[2:0]), .rd2_sel(rd2_sel[2:0]),
    .rd1_data(rd1_data_b), .rd2_data(rd2_data_b),
    .sb_set(sb_set), .sb_sel(sb_sel[2:0]),
    .rd1_busy(rd1_busy_b), .rd2_busy(rd2_busy_b)
  );

  // Reference model: a plain array of values, a busy flag per register and
  // a count of clock edges since reset was released.
  int          nreg;
  logic [31:0] mask;
  bit          zr, initidx, byp;
  int          since;
  logic [31:0] mrf [32];
  bit          mbusy [32];

  typedef struct {
    string       nm;
    int          dut;
    logic        r;
    logic [31:0] d1, d2;
    logic        b1, b2;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void set_model(input int n, input logic [31:0] m,
                                    input bit z, input bit ii, input bit b);
    nreg = n; mask = m; zr = z; initidx = ii; byp = b; since = 0;
    for (int i = 0; i < 32; i++) begin mrf[i] = 32'h0; mbusy[i] = 1'b0; end
  endfunction

  function automatic bit m_run();
    return rst && (since >= nreg);
  endfunction

  function automatic void rd_model(input int sel, output logic [31:0] d, output logic b);
    int s, ws, ss;
    s  = sel & (nreg - 1);
    ws = int'(wr_sel) & (nreg - 1);
    ss = int'(sb_sel) & (nreg - 1);
    d = 32'h0; b = 1'b0;
    if (!m_run() || (zr && s == 0)) return;
    if (byp && wr_en && ws == s) begin
      d = wr_data & mask;
      b = (sb_set && ss == s) ? mbusy[s] : 1'b0;
    end else begin
      d = mrf[s];
      b = mbusy[s];
    end
  endfunction

  function automatic void model_edge();
    int ws, ss;
    if (!rst) return;
    if (since < nreg) begin
      since++;
      if (since == nreg)
        for (int i = 0; i < nreg; i++)
          mrf[i] = (zr && i == 0) ? 32'h0 : (initidx ? (i & mask) : 32'h0);
      return;
    end
    ws = int'(wr_sel) & (nreg - 1);
    ss = int'(sb_sel) & (nreg - 1);
    if (wr_en) begin
      if (!(zr && ws == 0)) mrf[ws] = wr_data & mask;
      mbusy[ws] = 1'b0;
    end
    if (sb_set && !(zr && ss == 0)) mbusy[ss] = 1'b1;
  endfunction

  // Apply the current inputs for one cycle: queue the expected outputs,
  // then advance the model across the rising edge.
  task automatic step(input string nm);
    exp_t e;
    if (!rst) begin
      since = 0;
      for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
    end
    e.nm = nm; e.dut = cur; e.r = m_run();
    rd_model(int'(rd1_sel), e.d1, e.b1);
    rd_model(int'(rd2_sel), e.d2, e.b2);
    q.push_back(e);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Immediate check that an asserted reset has forced the outputs low.
  task automatic chk_rst(input string nm);
    logic        ar, ab1, ab2;
    logic [31:0] ad1, ad2;
    #1;
    if (cur == 0) begin
      ar = ready_a; ad1 = rd1_data_a; ad2 = rd2_data_a; ab1 = rd1_busy_a; ab2 = rd2_busy_a;
    end else begin
      ar = ready_b; ad1 = {28'h0, rd1_data_b}; ad2 = {28'h0, rd2_data_b};
      ab1 = rd1_busy_b; ab2 = rd2_busy_b;
    end
    total++;
    if ({ar, ab1, ab2, ad1, ad2} !== {3'b000, 64'h0}) begin
      bad++;
      $display("FAIL %s @%0t: reset state ready=%b b1=%b b2=%b d1=%h d2=%h",
               nm, $time, ar, ab1, ab2, ad1, ad2);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; sb_set = 1'b0;
  endtask

  function automatic logic [4:0] pick();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd7;
      default: return 5'($urandom_range(0, nreg - 1));
    endcase
  endfunction

  task automatic rnd();
    wr_en   = 1'($urandom_range(0, 1));
    wr_sel  = pick();
    wr_data = $urandom;
    rd1_sel = pick();
    rd2_sel = pick();
    sb_set  = ($urandom_range(0, 2) == 0);
    sb_sel  = pick();
  endtask

  // Monitor: compare every queued expectation against the selected instance.
  always @(negedge clk) begin
    exp_t        e;
    logic        ar, ab1, ab2;
    logic [31:0] ad1, ad2;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.dut == 0) begin
        ar = ready_a; ad1 = rd1_data_a; ad2 = rd2_data_a; ab1 = rd1_busy_a; ab2 = rd2_busy_a;
      end else begin
        ar = ready_b; ad1 = {28'h0, rd1_data_b}; ad2 = {28'h0, rd2_data_b};
        ab1 = rd1_busy_b; ab2 = rd2_busy_b;
      end
      total++;
      if ({ar, ad1, ad2, ab1, ab2} !== {e.r, e.d1, e.d2, e.b1, e.b2}) begin
        bad++;
        $display("FAIL %s @%0t: got ready=%b d1=%h d2=%h b1=%b b2=%b, want ready=%b d1=%h d2=%h b1=%b b2=%b",
                 e.nm, $time, ar, ad1, ad2, ab1, ab2, e.r, e.d1, e.d2, e.b1, e.b2);
      end
    end
  end

  // Watchdog: the whole sequence must finish within a bounded time.
  initial begin
    #200000;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL timeout @%0t: test did not complete (total=%0d bad=%0d)", $time, total, bad);
      $finish;
    end
  end

  initial begin
    cur = 0; rst = 1'b0;
    set_model(32, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
    idle(); wr_sel = '0; wr_data = '0; rd1_sel = '0; rd2_sel = '0; sb_sel = '0;
    @(posedge clk); #1;
    chk_rst("reset_state_a");

    // Held in reset, then the 32-edge sweep, then ready.
    repeat (3) begin rnd(); step("in_reset"); end
    rst = 1'b1;
    for (int k = 0; k < 32; k++) begin rnd(); step("sweep_a"); end
    idle();
    for (int i = 0; i < 32; i++) begin
      rd1_sel = 5'(i); rd2_sel = 5'(31 - i); step("init_read_a");
    end

    // Same-cycle forwarding of a write.
    wr_en = 1'b1; wr_sel = 5'd5; wr_data = 32'hDEAD_BEEF; rd1_sel = 5'd5; rd2_sel = 5'd4;
    step("bypass_r5");
    idle(); step("r5_after");

    // Hardwired r0.
    wr_en = 1'b1; wr_sel = 5'd0; wr_data = 32'h1234; rd1_sel = 5'd0; rd2_sel = 5'd0;
    step("wr_r0_bypass");
    idle(); step("rd_r0");
    sb_set = 1'b1; sb_sel = 5'd0; step("sb_r0_set");
    idle(); step("sb_r0_busy");

    // Scoreboard set, clear by write, and set-wins on collision.
    rd1_sel = 5'd7; rd2_sel = 5'd7;
    sb_set = 1'b1; sb_sel = 5'd7; step("sb_r7_set");
    idle(); step("r7_busy");
    wr_en = 1'b1; wr_sel = 5'd7; wr_data = 32'hA5A5_5A5A; step("wr_r7_clear");
    idle(); step("r7_cleared");
    wr_en = 1'b1; wr_sel = 5'd7; wr_data = 32'h77; sb_set = 1'b1; sb_sel = 5'd7;
    step("set_wins_same");
    idle(); step("set_wins_after");
    wr_en = 1'b1; wr_sel = 5'd7; wr_data = 32'h99; sb_set = 1'b1; sb_sel = 5'd9;
    rd2_sel = 5'd9; step("split_set_wr");
    idle(); step("split_after");

    repeat (300) begin rnd(); step("random_a"); end

    // Reset in RUN with a busy register, then reset mid-sweep at idx 10.
    idle(); sb_set = 1'b1; sb_sel = 5'd3; rd1_sel = 5'd3; rd2_sel = 5'd5; step("pre_rst");
    idle(); step("busy_before_rst");
    rst = 1'b0; chk_rst("rst_in_run_async"); step("rst_in_run");
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin rnd(); step("sweep_partial"); end
    idle(); rd1_sel = 5'd3; rd2_sel = 5'd9;
    rst = 1'b0; chk_rst("rst_mid_sweep_async"); step("rst_mid_sweep");
    step("rst_held");
    rst = 1'b1;
    for (int k = 0; k < 32; k++) begin rnd(); step("sweep_again"); end
    idle(); rd1_sel = 5'd3; rd2_sel = 5'd5; step("ready_again");
    repeat (50) begin rnd(); step("random_a2"); end

    // Small instance: 8 x 4 bits, zero init, no forwarding.
    idle(); cur = 1; rst = 1'b0;
    set_model(8, 32'hF, 1'b1, 1'b0, 1'b0);
    chk_rst("reset_state_b");
    step("b_reset");
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin rnd(); step("sweep_b"); end
    idle();
    for (int i = 0; i < 8; i++) begin
      rd1_sel = 5'(i); rd2_sel = 5'(7 - i); step("init_read_b");
    end
    wr_en = 1'b1; wr_sel = 5'd7; wr_data = 32'hF; rd1_sel = 5'd7; step("b_wr_r7_nobypass");
    idle(); step("b_r7_after");
    repeat (200) begin rnd(); step("random_b"); end

    idle();
    @(negedge clk); #1;
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
